// File: rtl/wm_phase_countdown.sv
// wm_phase_countdown: per-phase countdown timer for the washing-machine
// controller. Latches the target of the current phase on every controller
// state change, counts it down (with pause), and returns a one-cycle
// phase_done pulse when the phase expires.
// Optional build macro: WM_PHASE_ELAPSED_EN adds the elapsed_cnt output.
module wm_phase_countdown #(
  parameter int unsigned COUNT_W = 29,
  parameter int unsigned STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state_in,
  input  logic [COUNT_W-1:0] filling_cnt,
  input  logic [COUNT_W-1:0] washing_cnt,
  input  logic [COUNT_W-1:0] rinsing_cnt,
  input  logic [COUNT_W-1:0] spinning_cnt,
  input  logic               pause,
  output logic               phase_done,
  output logic               busy,
  output logic [COUNT_W-1:0] remaining_cnt,
`ifdef WM_PHASE_ELAPSED_EN
  output logic [COUNT_W-1:0] elapsed_cnt,
`endif
  output logic               bad_state
);

  // Controller state codes as seen on state_in
  localparam logic [STATE_W-1:0] ST_IDLE  = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_FILL  = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_WASH  = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_RINSE = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_SPIN  = STATE_W'(4);

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_PAUSE,
    T_DONE
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               phase_done_q, phase_done_d;
  logic               busy_q, busy_d;
  logic               bad_state_q, bad_state_d;
`ifdef WM_PHASE_ELAPSED_EN
  logic [COUNT_W-1:0] elapsed_q, elapsed_d;
`endif

  logic [COUNT_W-1:0] sel_cnt;
  logic               chg;

  // Target mux: pick the count belonging to the requested phase
  always_comb begin
    sel_cnt = '0;
    case (state_in)
      ST_FILL:  sel_cnt = filling_cnt;
      ST_WASH:  sel_cnt = washing_cnt;
      ST_RINSE: sel_cnt = rinsing_cnt;
      ST_SPIN:  sel_cnt = spinning_cnt;
      default:  sel_cnt = '0;
    endcase
  end

  assign chg     = (state_in != state_q);
  assign state_d = state_in;

  // Next-state and registered-output logic; a phase change overrides all
  always_comb begin
    fsm_d        = fsm_q;
    remaining_d  = remaining_q;
    phase_done_d = 1'b0;
    bad_state_d  = bad_state_q;
`ifdef WM_PHASE_ELAPSED_EN
    elapsed_d    = elapsed_q;
`endif
    if (chg) begin
`ifdef WM_PHASE_ELAPSED_EN
      elapsed_d = '0;
`endif
      if (state_in == ST_IDLE) begin
        fsm_d       = T_IDLE;
        remaining_d = '0;
      end else if (state_in > ST_SPIN) begin
        fsm_d       = T_IDLE;
        remaining_d = '0;
        bad_state_d = 1'b1;
      end else if (sel_cnt == '0) begin
        fsm_d        = T_DONE;
        remaining_d  = '0;
        phase_done_d = 1'b1;
      end else begin
        remaining_d = sel_cnt;
        fsm_d       = pause ? T_PAUSE : T_RUN;
      end
    end else begin
      case (fsm_q)
        T_RUN: begin
          if (pause) begin
            fsm_d = T_PAUSE;
          end else if (remaining_q == COUNT_W'(1)) begin
            remaining_d  = '0;
            fsm_d        = T_DONE;
            phase_done_d = 1'b1;
`ifdef WM_PHASE_ELAPSED_EN
            elapsed_d    = elapsed_q + COUNT_W'(1);
`endif
          end else if (remaining_q != '0) begin
            remaining_d = remaining_q - COUNT_W'(1);
`ifdef WM_PHASE_ELAPSED_EN
            elapsed_d   = elapsed_q + COUNT_W'(1);
`endif
          end
        end
        T_PAUSE: begin
          if (!pause) fsm_d = T_RUN;
        end
        default: begin
          remaining_d = '0;
        end
      endcase
    end
    busy_d = (fsm_d == T_RUN) || (fsm_d == T_PAUSE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= T_IDLE;
      state_q      <= '0;
      remaining_q  <= '0;
      phase_done_q <= 1'b0;
      busy_q       <= 1'b0;
      bad_state_q  <= 1'b0;
`ifdef WM_PHASE_ELAPSED_EN
      elapsed_q    <= '0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      phase_done_q <= phase_done_d;
      busy_q       <= busy_d;
      bad_state_q  <= bad_state_d;
`ifdef WM_PHASE_ELAPSED_EN
      elapsed_q    <= elapsed_d;
`endif
    end
  end

  assign phase_done    = phase_done_q;
  assign busy          = busy_q;
  assign remaining_cnt = remaining_q;
  assign bad_state     = bad_state_q;
`ifdef WM_PHASE_ELAPSED_EN
  assign elapsed_cnt   = elapsed_q;
`endif

endmodule
